enet_ext_bus_arbiter: RTL and testbench

- Shares the single external Ethernet controller bus between two requesters: master 0 is the Nios CPU data port, master 1 is the packet DMA engine.
- Sequences each access as setup, strobe and hold phases with fixed cycle counts, then returns read data and a one-cycle ack to the granted master.
- Sits between the enet_nios bus fabric and the board-level chip-select, read and write pins.

---
 rtl/enet_bus_pkg.sv | 16 +
 rtl/enet_rr_arb2.sv | 18 +
 rtl/enet_ext_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_enet_ext_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enet_bus_pkg.sv
// Shared types and timing defaults for the external Ethernet controller bus arbiter.
package enet_bus_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} bus_state_e;

  localparam int CNT_W          = 4;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 3;
  localparam int DEF_HOLD_CYC   = 1;

  // Counter value loaded on entry to a phase of 'cyc' cycles.
  function automatic logic [CNT_W-1:0] phase_load(input int cyc);
    return (cyc > 0) ? CNT_W'(cyc - 1) : '0;
  endfunction

endpackage

// File: rtl/enet_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the master that did not win last time.
module enet_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/enet_ext_bus_arbiter.sv
// Arbitrates the Nios data port and packet DMA onto the external Ethernet controller
// bus, sequencing setup/strobe/hold phases with registered, glitch-free strobes.
module enet_ext_bus_arbiter
  import enet_bus_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic              ext_data_oe,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic              ext_cs_n,
  output logic              ext_rd_n,
  output logic              ext_wr_n
);

  localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

  bus_state_e       r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last, r_owner, r_wr;
  logic [1:0]       w_gnt;
  logic             w_start, w_sel, w_wr, w_busy;

  enet_rr_arb2 u_arb (
    .i_req        ({m1_req, m0_req}),
    .i_last_grant (r_last),
    .o_grant      (w_gnt)
  );

  assign w_start = (r_state == IDLE) && (|w_gnt);
  assign w_sel   = w_gnt[1];
  // Direction of the access about to run: freshly granted master or the latched one.
  assign w_wr    = w_start ? (w_sel ? m1_wr : m0_wr) : r_wr;
  assign w_busy  = (w_nxt == SETUP) || (w_nxt == STROBE) || (w_nxt == HOLD);

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (SETUP_CYC > 0) begin
            w_nxt = SETUP;  w_cnt_nxt = SETUP_LD;
          end else begin
            w_nxt = STROBE; w_cnt_nxt = STROBE_LD;
          end
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_nxt = STROBE; w_cnt_nxt = STROBE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      STROBE: begin
        if (r_cnt == '0) begin
          if (HOLD_CYC > 0) begin
            w_nxt = HOLD; w_cnt_nxt = HOLD_LD;
          end else begin
            w_nxt = DONE; w_cnt_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_nxt = DONE; w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE:    begin w_nxt = IDLE; w_cnt_nxt = '0; end
      default: begin w_nxt = IDLE; w_cnt_nxt = '0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_wr        <= 1'b0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
      m_rdata     <= '0;
      ext_cs_n    <= 1'b1;
      ext_rd_n    <= 1'b1;
      ext_wr_n    <= 1'b1;
      ext_data_oe <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) begin
        r_owner   <= w_sel;
        r_last    <= w_sel;
        r_wr      <= w_wr;
        ext_addr  <= w_sel ? m1_addr  : m0_addr;
        ext_wdata <= w_sel ? m1_wdata : m0_wdata;
      end
      // Pin levels follow the state being entered, so they change exactly on the edge.
      ext_cs_n    <= !w_busy;
      ext_rd_n    <= !((w_nxt == STROBE) && !w_wr);
      ext_wr_n    <= !((w_nxt == STROBE) && w_wr);
      ext_data_oe <= w_busy && w_wr;
      m0_ack      <= (w_nxt == DONE) && !r_owner;
      m1_ack      <= (w_nxt == DONE) && r_owner;
      if ((r_state == STROBE) && (r_cnt == '0) && !r_wr)
        m_rdata <= ext_rdata;
    end
  end

endmodule

// File: tb/tb_enet_ext_bus_arbiter.sv
// Scenario bench for enet_ext_bus_arbiter: per-cycle pin checks plus an ack scoreboard.
module tb_enet_ext_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [7:0]  m0_addr = '0, m1_addr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0, ext_rdata = '0;
  logic        m0_ack, m1_ack, ext_data_oe, ext_cs_n, ext_rd_n, ext_wr_n;
  logic [15:0] m_rdata, ext_wdata;
  logic [7:0]  ext_addr;

  logic        f_m0_req = 1'b0, f_m0_wr = 1'b0, f_m1_req = 1'b0, f_m1_wr = 1'b0;
  logic [7:0]  f_m0_addr = '0, f_m1_addr = '0;
  logic [15:0] f_m0_wdata = '0, f_m1_wdata = '0, f_ext_rdata = '0;
  logic        f_m0_ack, f_m1_ack, f_ext_data_oe, f_ext_cs_n, f_ext_rd_n, f_ext_wr_n;
  logic [15:0] f_m_rdata, f_ext_wdata;
  logic [7:0]  f_ext_addr;

  typedef struct {
    logic        m;
    logic [7:0]  addr;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  enet_ext_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m_rdata(m_rdata),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_data_oe(ext_data_oe),
    .ext_rdata(ext_rdata), .ext_cs_n(ext_cs_n), .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n)
  );

  enet_ext_bus_arbiter #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut_f (
    .clk(clk), .reset(reset),
    .m0_req(f_m0_req), .m0_wr(f_m0_wr), .m0_addr(f_m0_addr), .m0_wdata(f_m0_wdata),
    .m1_req(f_m1_req), .m1_wr(f_m1_wr), .m1_addr(f_m1_addr), .m1_wdata(f_m1_wdata),
    .m0_ack(f_m0_ack), .m1_ack(f_m1_ack), .m_rdata(f_m_rdata),
    .ext_addr(f_ext_addr), .ext_wdata(f_ext_wdata), .ext_data_oe(f_ext_data_oe),
    .ext_rdata(f_ext_rdata), .ext_cs_n(f_ext_cs_n), .ext_rd_n(f_ext_rd_n), .ext_wr_n(f_ext_wr_n)
  );

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, m0_ack, m1_ack} !== 6'b111000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=111000",
               {ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, m0_ack, m1_ack});
    end
    checks++;
    if ({ext_addr, ext_wdata, m_rdata} !== 40'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp=0", ext_addr, ext_wdata, m_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    logic exp_cs, exp_rd;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h10; ext_rdata = 16'hBEEF;
    sb.push_back('{m: 1'b0, addr: 8'h10, rdata: 16'hBEEF});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_cs = !(k >= 1 && k <= 5);
      exp_rd = !(k >= 2 && k <= 4);
      checks++;
      if ({ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, m0_ack} !== {exp_cs, exp_rd, 1'b1, 1'b0, k == 6}) begin
        failures++;
        $display("FAIL read_pins k=%0d got cs=%b rd=%b wr=%b oe=%b ack=%b exp cs=%b rd=%b wr=1 oe=0 ack=%b",
                 k, ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, m0_ack, exp_cs, exp_rd, k == 6);
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL read_sb unexpected ack k=%0d", k);
        end else begin
          e = sb.pop_front();
          if ({m1_ack, m0_ack} !== (e.m ? 2'b10 : 2'b01) || ext_addr !== e.addr || m_rdata !== e.rdata) begin
            failures++;
            $display("FAIL read_sb got acks=%b addr=%h rdata=%h exp m=%b addr=%h rdata=%h",
                     {m1_ack, m0_ack}, ext_addr, m_rdata, e.m, e.addr, e.rdata);
          end
        end
      end
      if (k == 6) m0_req = 1'b0;
    end
  endtask

  task automatic test_single_write;
    logic exp_cs, exp_wr, exp_oe;
    @(negedge clk);
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h22; m1_wdata = 16'h1234; ext_rdata = 16'hDEAD;
    sb.push_back('{m: 1'b1, addr: 8'h22, rdata: 16'hBEEF});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_cs = !(k >= 1 && k <= 5);
      exp_wr = !(k >= 2 && k <= 4);
      exp_oe = (k >= 1 && k <= 5);
      checks++;
      if ({ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, m1_ack} !== {exp_cs, 1'b1, exp_wr, exp_oe, k == 6}) begin
        failures++;
        $display("FAIL write_pins k=%0d got cs=%b rd=%b wr=%b oe=%b ack=%b exp cs=%b rd=1 wr=%b oe=%b ack=%b",
                 k, ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, m1_ack, exp_cs, exp_wr, exp_oe, k == 6);
      end
      if (k == 3) begin
        checks++;
        if (ext_wdata !== 16'h1234) begin
          failures++; $display("FAIL write_wdata got=%h exp=1234", ext_wdata);
        end
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL write_sb unexpected ack k=%0d", k);
        end else begin
          e = sb.pop_front();
          if ({m1_ack, m0_ack} !== (e.m ? 2'b10 : 2'b01) || ext_addr !== e.addr || m_rdata !== e.rdata) begin
            failures++;
            $display("FAIL write_sb got acks=%b addr=%h rdata=%h exp m=%b addr=%h rdata=%h",
                     {m1_ack, m0_ack}, ext_addr, m_rdata, e.m, e.addr, e.rdata);
          end
        end
      end
      if (k == 6) m1_req = 1'b0;
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_acks;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h30;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h31; ext_rdata = 16'h5A5A;
    for (int i = 0; i < 4; i++)
      sb.push_back('{m: i[0], addr: (i[0] ? 8'h31 : 8'h30), rdata: 16'h5A5A});
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      exp_acks = {(k == 13 || k == 27), (k == 6 || k == 20)};
      checks++;
      if ({m1_ack, m0_ack} !== exp_acks) begin
        failures++;
        $display("FAIL rr_acks k=%0d got=%b exp=%b", k, {m1_ack, m0_ack}, exp_acks);
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rr_sb unexpected ack k=%0d", k);
        end else begin
          e = sb.pop_front();
          if ({m1_ack, m0_ack} !== (e.m ? 2'b10 : 2'b01) || ext_addr !== e.addr || m_rdata !== e.rdata) begin
            failures++;
            $display("FAIL rr_sb k=%0d got acks=%b addr=%h rdata=%h exp m=%b addr=%h rdata=%h",
                     k, {m1_ack, m0_ack}, ext_addr, m_rdata, e.m, e.addr, e.rdata);
          end
        end
      end
      if (k == 27) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
  endtask

  task automatic test_addr_change;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h10; ext_rdata = 16'h0077;
    sb.push_back('{m: 1'b0, addr: 8'h10, rdata: 16'h0077});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 5) begin
        checks++;
        if (ext_addr !== 8'h10) begin
          failures++; $display("FAIL addr_hold k=%0d got=%h exp=10", k, ext_addr);
        end
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL addr_sb unexpected ack k=%0d", k);
        end else begin
          e = sb.pop_front();
          if (k != 6 || {m1_ack, m0_ack} !== (e.m ? 2'b10 : 2'b01) || ext_addr !== e.addr || m_rdata !== e.rdata) begin
            failures++;
            $display("FAIL addr_sb k=%0d got acks=%b addr=%h rdata=%h exp k=6 m=%b addr=%h rdata=%h",
                     k, {m1_ack, m0_ack}, ext_addr, m_rdata, e.m, e.addr, e.rdata);
          end
        end
      end
      if (k == 2) m0_addr = 8'h11;
      if (k == 6) m0_req = 1'b0;
    end
    m0_addr = 8'h10;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h40; m0_wdata = 16'hA5A5;
    repeat (3) @(negedge clk);
    checks++;
    if ({ext_cs_n, ext_wr_n, ext_data_oe} !== 3'b001) begin
      failures++; $display("FAIL rstmid_strobe got cs/wr/oe=%b exp=001", {ext_cs_n, ext_wr_n, ext_data_oe});
    end
    reset = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ext_cs_n, ext_wr_n, ext_data_oe, m0_ack, m_rdata} !== {4'b1100, 16'h0}) begin
      failures++;
      $display("FAIL rstmid_abort got cs=%b wr=%b oe=%b ack=%b rdata=%h exp cs=1 wr=1 oe=0 ack=0 rdata=0",
               ext_cs_n, ext_wr_n, ext_data_oe, m0_ack, m_rdata);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({m1_ack, m0_ack, ext_cs_n} !== 3'b001) begin
        failures++; $display("FAIL rstmid_quiet k=%0d got acks=%b cs=%b exp acks=00 cs=1", k, {m1_ack, m0_ack}, ext_cs_n);
      end
    end
    m0_req = 1'b1;
    sb.push_back('{m: 1'b0, addr: 8'h40, rdata: 16'h0000});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if ({ext_wr_n, m0_ack} !== {!(k >= 2 && k <= 4), k == 6}) begin
        failures++;
        $display("FAIL rstmid_retry k=%0d got wr=%b ack=%b exp wr=%b ack=%b", k, ext_wr_n, m0_ack, !(k >= 2 && k <= 4), k == 6);
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rstmid_sb unexpected ack k=%0d", k);
        end else begin
          e = sb.pop_front();
          if ({m1_ack, m0_ack} !== (e.m ? 2'b10 : 2'b01) || ext_addr !== e.addr || ext_wdata !== 16'hA5A5 || m_rdata !== e.rdata) begin
            failures++;
            $display("FAIL rstmid_sb got acks=%b addr=%h wdata=%h rdata=%h exp m=%b addr=%h wdata=a5a5 rdata=%h",
                     {m1_ack, m0_ack}, ext_addr, ext_wdata, m_rdata, e.m, e.addr, e.rdata);
          end
        end
      end
      if (k == 6) m0_req = 1'b0;
    end
  endtask

  task automatic test_fast_timing;
    @(negedge clk);
    f_m0_req = 1'b1; f_m0_wr = 1'b0; f_m0_addr = 8'h05; f_ext_rdata = 16'hC3C3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({f_ext_cs_n, f_ext_rd_n, f_m0_ack} !== {k != 1, k != 1, k == 2}) begin
        failures++;
        $display("FAIL fast_pins k=%0d got cs=%b rd=%b ack=%b exp cs=%b rd=%b ack=%b",
                 k, f_ext_cs_n, f_ext_rd_n, f_m0_ack, k != 1, k != 1, k == 2);
      end
      if (k == 2) f_m0_req = 1'b0;
    end
    checks++;
    if (f_m_rdata !== 16'hC3C3) begin
      failures++; $display("FAIL fast_rdata got=%h exp=c3c3", f_m_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_addr_change();
    test_reset_mid();
    test_fast_timing();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
